// File: rtl/mem_stage.sv
// RV32I memory stage: one req/ack data-bus transaction per load/store, load alignment/extension,
// writeback record. Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHK_EN.
module mem_stage #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstl,
    input  logic [10:0] opcode_exe_2_mem_i,
    input  logic [4:0]  rd_exe_2_mem_i,
    input  logic [31:0] rd_data_exe_2_mem_i,
    input  logic [31:0] mem_data_i,
    input  logic        load_valid_i,
    input  logic        store_valid_i,
    output logic        stall_mem_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [4:0]  rd_mem_2_wb_o,
    output logic [31:0] rd_data_mem_2_wb_o,
    output logic        wb_valid_o,
    output logic        bus_err_o,
    output logic        misalign_o
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dmem_req_t;

    logic [0:0]    state;
    logic [CW-1:0] tmo_cnt;
    logic [2:0]    ld_f3;
    logic [1:0]    ld_a;
    logic [4:0]    ld_rd;
    logic          ld_is_load;

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [1:0]  a;
    logic        is_load, is_store, is_mem, mis, wb_ok;
    dmem_req_t   req_d;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_f7b5;

    assign opc         = opcode_exe_2_mem_i[6:0];
    assign funct3      = opcode_exe_2_mem_i[9:7];
    assign unused_f7b5 = opcode_exe_2_mem_i[10];
    assign a           = rd_data_exe_2_mem_i[1:0];
    // A request flagged as both load and store is taken as a load.
    assign is_load     = load_valid_i;
    assign is_store    = store_valid_i & ~load_valid_i;
    assign is_mem      = is_load | is_store;
    assign stall_mem_o = (state == ACCESS);

    always_comb begin
        wb_ok = 1'b0;
        case (opc)
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: wb_ok = (rd_exe_2_mem_i != 5'd0);
            default: wb_ok = 1'b0;
        endcase
    end

    always_comb begin
        req_d.we   = is_store;
        req_d.addr = {rd_data_exe_2_mem_i[31:2], 2'b00};
        req_d.be   = 4'b1111;
        req_d.wdata = 32'd0;
        if (is_store) begin
            case (funct3)
                3'b000: begin
                    req_d.be    = 4'b0001 << a;
                    req_d.wdata = {4{mem_data_i[7:0]}};
                end
                3'b001: begin
                    req_d.be    = 4'b0011 << {a[1], 1'b0};
                    req_d.wdata = {2{mem_data_i[15:0]}};
                end
                default: begin
                    req_d.be    = 4'b1111;
                    req_d.wdata = mem_data_i;
                end
            endcase
        end
    end

    // Lane select uses the address bits latched at issue, not the (already advanced) inputs.
    always_comb begin
        ld_byte = 8'(dmem_rdata_i >> {ld_a, 3'b000});
        ld_half = ld_a[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (ld_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

`ifdef MEM_MISALIGN_CHK_EN
    always_comb begin
        case (funct3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = |a;
            default: mis = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) misalign_o <= 1'b0;
        else       misalign_o <= (state == IDLE) && is_mem && mis;
    end
`else
    assign mis        = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            state              <= IDLE;
            tmo_cnt            <= '0;
            dmem_req_o         <= 1'b0;
            dmem_we_o          <= 1'b0;
            dmem_addr_o        <= 32'd0;
            dmem_be_o          <= 4'd0;
            dmem_wdata_o       <= 32'd0;
            rd_mem_2_wb_o      <= 5'd0;
            rd_data_mem_2_wb_o <= 32'd0;
            wb_valid_o         <= 1'b0;
            bus_err_o          <= 1'b0;
            ld_f3              <= 3'd0;
            ld_a               <= 2'd0;
            ld_rd              <= 5'd0;
            ld_is_load         <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (is_mem && !mis) begin
                        state        <= ACCESS;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= req_d.we;
                        dmem_addr_o  <= req_d.addr;
                        dmem_be_o    <= req_d.be;
                        dmem_wdata_o <= req_d.wdata;
                        ld_f3        <= funct3;
                        ld_a         <= a;
                        ld_rd        <= rd_exe_2_mem_i;
                        ld_is_load   <= is_load;
                    end else if (!is_mem) begin
                        rd_mem_2_wb_o      <= rd_exe_2_mem_i;
                        rd_data_mem_2_wb_o <= rd_data_exe_2_mem_i;
                        wb_valid_o         <= wb_ok;
                    end
                end
                ACCESS: begin
                    // Ack on the final timeout edge still completes normally.
                    if (dmem_ack_i) begin
                        state      <= IDLE;
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        if (ld_is_load) begin
                            rd_mem_2_wb_o      <= ld_rd;
                            rd_data_mem_2_wb_o <= ld_data;
                            wb_valid_o         <= (ld_rd != 5'd0);
                        end
                    end else if (ACK_TIMEOUT != 0 && tmo_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        state      <= IDLE;
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        bus_err_o  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
